// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, byte classification and
// data-byte counts, plus the serial receiver state encoding.
package midi_pkg;

    localparam logic [3:0] ST_NOTE_OFF   = 4'h8;
    localparam logic [3:0] ST_NOTE_ON    = 4'h9;
    localparam logic [3:0] ST_POLY_AT    = 4'hA;
    localparam logic [3:0] ST_CTRL       = 4'hB;
    localparam logic [3:0] ST_PROG       = 4'hC;
    localparam logic [3:0] ST_CHAN_AT    = 4'hD;
    localparam logic [3:0] ST_PITCH      = 4'hE;

    localparam logic [7:0] SYS_FIRST     = 8'hF0;
    localparam logic [7:0] RT_FIRST      = 8'hF8;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;

    typedef enum logic [1:0] {
        BK_DATA     = 2'd0,
        BK_STATUS   = 2'd1,
        BK_SYSTEM   = 2'd2,
        BK_REALTIME = 2'd3
    } byte_kind_e;

    // Sort a received byte into the four classes the parser cares about.
    function automatic byte_kind_e classify_byte(input logic [7:0] b);
        byte_kind_e k;
        if (b >= RT_FIRST) begin
            k = BK_REALTIME;
        end else if (b >= SYS_FIRST) begin
            k = BK_SYSTEM;
        end else if (b[7]) begin
            k = BK_STATUS;
        end else begin
            k = BK_DATA;
        end
        return k;
    endfunction

    // Number of data bytes following a channel status nibble.
    function automatic logic [1:0] data_byte_count(input logic [3:0] nib);
        logic [1:0] n;
        case (nib)
            ST_PROG, ST_CHAN_AT: n = 2'd1;
            default:             n = 2'd2;
        endcase
        return n;
    endfunction

    // True for the two statuses that carry note events.
    function automatic logic is_note_status(input logic [3:0] nib);
        return (nib == ST_NOTE_OFF) || (nib == ST_NOTE_ON);
    endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial byte receiver: input synchroniser, start-bit glitch
// rejection, mid-bit sampling, framing-error detection and counting.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 31250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic [7:0] err_count
);

    localparam int BIT_CYC  = CLK_HZ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = ($clog2(BIT_CYC + 1) > 12) ? $clog2(BIT_CYC + 1) : 12;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       err_count_q, err_count_d;
    logic             rx_s1_q, rx_s1_d;
    logic             rx_s2_q, rx_s2_d;
    logic             rx_prev_q, rx_prev_d;

    // Next-state logic for the synchroniser, bit timing and byte assembly.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        err_count_d  = err_count_q;
        rx_s1_d      = rx;
        rx_s2_d      = rx_s1_q;
        rx_prev_d    = rx_s2_q;
        case (state_q)
            RX_IDLE: begin
                if (!rx_s2_q && rx_prev_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s2_q) begin
                        state_d   = RX_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s2_q) begin
                        byte_valid_d = 1'b1;
                        byte_d       = shift_q;
                        state_d      = RX_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RX_BREAK;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end else begin
                            err_count_d = err_count_q;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RX_BREAK: begin
                if (rx_s2_q) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_BREAK;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // Receiver state register; line sync flops reset to idle-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'd0;
            byte_q       <= 8'd0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_count_q  <= 8'd0;
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            err_count_q  <= err_count_d;
            rx_s1_q      <= rx_s1_d;
            rx_s2_q      <= rx_s2_d;
            rx_prev_q    <= rx_prev_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign rx_byte    = byte_q;
    assign frame_err  = frame_err_q;
    assign err_count  = err_count_q;

endmodule

// File: rtl/midi_rx.sv
// MIDI receiver top: byte receiver plus Note On/Off parser with running
// status, channel filter and a 10-key held-note map.
module midi_rx
    import midi_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 31250,
    parameter int BASE_NOTE = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic [3:0] channel,
    input  logic       omni,
    output logic [9:0] note,
    output logic [6:0] velocity,
    output logic       ev_valid,
    output logic       ev_on,
    output logic [6:0] ev_num,
    output logic       frame_err,
    output logic [7:0] err_count
);

    localparam logic [6:0] BASE = 7'(BASE_NOTE);

    logic       byte_valid_s;
    logic [7:0] rx_byte_s;

    midi_uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_valid (byte_valid_s),
        .rx_byte    (rx_byte_s),
        .frame_err  (frame_err),
        .err_count  (err_count)
    );

    logic       rs_valid_q, rs_valid_d;
    logic [7:0] rs_status_q, rs_status_d;
    logic       data_idx_q, data_idx_d;
    logic [6:0] data1_q, data1_d;
    logic [9:0] note_q, note_d;
    logic [6:0] velocity_q, velocity_d;
    logic       ev_valid_q, ev_valid_d;
    logic       ev_on_q, ev_on_d;
    logic [6:0] ev_num_q, ev_num_d;

    logic [3:0] status_nib_s;
    logic       accept_s;
    logic       is_on_s;
    logic [6:0] offset_s;
    logic       in_range_s;

    assign status_nib_s = rs_status_q[7:4];
    assign accept_s     = is_note_status(status_nib_s) &&
                          (omni || (rs_status_q[3:0] == channel));
    assign is_on_s      = (status_nib_s == ST_NOTE_ON) && (rx_byte_s[6:0] != 7'd0);
    // Offset is only trusted when the number is at or above the base note,
    // so a note below the base can never wrap into the map.
    assign offset_s     = data1_q - BASE;
    assign in_range_s   = (data1_q >= BASE) && (offset_s < 7'd10);

    // Message parser: running status, data-byte counting and note events.
    always_comb begin
        rs_valid_d  = rs_valid_q;
        rs_status_d = rs_status_q;
        data_idx_d  = data_idx_q;
        data1_d     = data1_q;
        note_d      = note_q;
        velocity_d  = velocity_q;
        ev_valid_d  = 1'b0;
        ev_on_d     = ev_on_q;
        ev_num_d    = ev_num_q;
        if (byte_valid_s) begin
            case (classify_byte(rx_byte_s))
                BK_REALTIME: begin
                    rs_valid_d = rs_valid_q;
                end
                BK_SYSTEM: begin
                    rs_valid_d = 1'b0;
                    data_idx_d = 1'b0;
                end
                BK_STATUS: begin
                    rs_valid_d  = 1'b1;
                    rs_status_d = rx_byte_s;
                    data_idx_d  = 1'b0;
                end
                BK_DATA: begin
                    if (!rs_valid_q) begin
                        data_idx_d = data_idx_q;
                    end else if (!data_idx_q) begin
                        data1_d = rx_byte_s[6:0];
                        if (data_byte_count(status_nib_s) == 2'd1) begin
                            data_idx_d = 1'b0;
                        end else begin
                            data_idx_d = 1'b1;
                        end
                    end else begin
                        data_idx_d = 1'b0;
                        if (accept_s) begin
                            ev_valid_d = 1'b1;
                            ev_num_d   = data1_q;
                            ev_on_d    = is_on_s;
                            if (is_on_s) begin
                                velocity_d = rx_byte_s[6:0];
                            end else begin
                                velocity_d = velocity_q;
                            end
                            if (in_range_s) begin
                                note_d[offset_s[3:0]] = is_on_s;
                            end else begin
                                note_d = note_q;
                            end
                        end else begin
                            ev_valid_d = 1'b0;
                        end
                    end
                end
                default: begin
                    rs_valid_d = rs_valid_q;
                end
            endcase
        end else begin
            ev_valid_d = 1'b0;
        end
    end

    // Parser and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_valid_q  <= 1'b0;
            rs_status_q <= 8'd0;
            data_idx_q  <= 1'b0;
            data1_q     <= 7'd0;
            note_q      <= 10'd0;
            velocity_q  <= 7'd0;
            ev_valid_q  <= 1'b0;
            ev_on_q     <= 1'b0;
            ev_num_q    <= 7'd0;
        end else begin
            rs_valid_q  <= rs_valid_d;
            rs_status_q <= rs_status_d;
            data_idx_q  <= data_idx_d;
            data1_q     <= data1_d;
            note_q      <= note_d;
            velocity_q  <= velocity_d;
            ev_valid_q  <= ev_valid_d;
            ev_on_q     <= ev_on_d;
            ev_num_q    <= ev_num_d;
        end
    end

    assign note     = note_q;
    assign velocity = velocity_q;
    assign ev_valid = ev_valid_q;
    assign ev_on    = ev_on_q;
    assign ev_num   = ev_num_q;

endmodule
